// File: rtl/lpif_tx_framer.sv
// rtl/lpif_tx_framer.sv - LPIF transmit framer: beat FIFO, lp_irdy/pl_trdy drive, state_req bring-up FSM, exit_cg ack.
// Optional LPIF_TX_TLPEDB_EN adds a per-byte TLP EDB marker carried alongside the beat.
module lpif_tx_framer #(
    parameter int LPIF_BUS_WIDTH = 256,
    parameter int FIFO_DEPTH     = 8,
    parameter int ACTIVE_TIMEOUT = 1024,
    localparam int B  = LPIF_BUS_WIDTH / 8,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int LW = AW + 1,
    localparam int TW = $clog2(ACTIVE_TIMEOUT + 1)
) (
    input  logic                      lclk,
    input  logic                      reset,
    input  logic                      link_en,
    input  logic                      force_detect,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LPIF_BUS_WIDTH-1:0] in_data,
    input  logic [B-1:0]              in_valid_b,
    input  logic [B-1:0]              in_tlp_start,
    input  logic [B-1:0]              in_tlp_end,
    input  logic [B-1:0]              in_dllp_start,
    input  logic [B-1:0]              in_dllp_end,
`ifdef LPIF_TX_TLPEDB_EN
    input  logic [B-1:0]              in_tlpedb,
`endif
    output logic                      lp_irdy,
    input  logic                      pl_trdy,
    output logic [LPIF_BUS_WIDTH-1:0] lp_data,
    output logic [B-1:0]              lp_valid,
    output logic [B-1:0]              lp_tlp_start,
    output logic [B-1:0]              lp_tlp_end,
    output logic [B-1:0]              lp_dllp_start,
    output logic [B-1:0]              lp_dllp_end,
    output logic [B-1:0]              lp_tlpedb,
    output logic [3:0]                lp_state_req,
    input  logic [3:0]                pl_state_sts,
    output logic                      lp_force_detect,
    input  logic                      pl_exit_cg_req,
    output logic                      lp_exit_cg_ack,
    output logic [LW-1:0]             fifo_level,
    output logic                      timeout_err
);

    typedef enum logic [1:0] {
        ST_RESET      = 2'd0,
        ST_REQ_ACTIVE = 2'd1,
        ST_ACTIVE     = 2'd2,
        ST_STALL      = 2'd3
    } state_t;

    localparam logic [3:0] STS_ACTIVE = 4'h1;

    state_t          state_q, state_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            timeout_set;
    logic            timeout_err_q;
    logic            force_detect_q;
    logic            exit_cg_ack_q, exit_cg_ack_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic            push, pop, empty, phy_active;

    logic [LPIF_BUS_WIDTH-1:0] data_mem_q  [FIFO_DEPTH];
    logic [B-1:0]              valid_mem_q [FIFO_DEPTH];
    logic [B-1:0]              ts_mem_q    [FIFO_DEPTH];
    logic [B-1:0]              te_mem_q    [FIFO_DEPTH];
    logic [B-1:0]              ds_mem_q    [FIFO_DEPTH];
    logic [B-1:0]              de_mem_q    [FIFO_DEPTH];

    assign phy_active = (pl_state_sts == STS_ACTIVE);
    assign empty      = (level_q == '0);
    assign in_ready   = (level_q != LW'(FIFO_DEPTH));
    assign lp_irdy    = !empty && (state_q == ST_ACTIVE) && phy_active;
    // A full FIFO refuses writes regardless of a same-cycle pop, so in_ready never depends on pl_trdy.
    assign push       = in_valid && in_ready;
    assign pop        = lp_irdy && pl_trdy;

    always_comb begin
        state_d     = state_q;
        tcnt_d      = '0;
        timeout_set = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (link_en) state_d = ST_REQ_ACTIVE;
            end
            ST_REQ_ACTIVE: begin
                if (phy_active) begin
                    state_d = ST_ACTIVE;
                end else if (tcnt_q == TW'(ACTIVE_TIMEOUT - 1)) begin
                    timeout_set = 1'b1;
                    state_d     = ST_RESET;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!phy_active) state_d = ST_STALL;
            end
            ST_STALL: begin
                if (phy_active) state_d = ST_ACTIVE;
            end
            default: state_d = ST_RESET;
        endcase
        if (!link_en || force_detect) state_d = ST_RESET;
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;
    end

    // Once granted, the ack follows the request down even if the FSM has since returned to RESET.
    assign exit_cg_ack_d = pl_exit_cg_req && (exit_cg_ack_q || (state_q != ST_RESET));

    always_ff @(posedge lclk) begin
        if (reset) begin
            state_q        <= ST_RESET;
            tcnt_q         <= '0;
            timeout_err_q  <= 1'b0;
            force_detect_q <= 1'b0;
            exit_cg_ack_q  <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
        end else begin
            state_q        <= state_d;
            tcnt_q         <= tcnt_d;
            timeout_err_q  <= timeout_err_q || timeout_set;
            force_detect_q <= force_detect;
            exit_cg_ack_q  <= exit_cg_ack_d;
            level_q        <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge lclk) begin
        if (push) begin
            data_mem_q[wr_ptr_q]  <= in_data;
            valid_mem_q[wr_ptr_q] <= in_valid_b;
            ts_mem_q[wr_ptr_q]    <= in_tlp_start;
            te_mem_q[wr_ptr_q]    <= in_tlp_end;
            ds_mem_q[wr_ptr_q]    <= in_dllp_start;
            de_mem_q[wr_ptr_q]    <= in_dllp_end;
        end
    end

`ifdef LPIF_TX_TLPEDB_EN
    logic [B-1:0] edb_mem_q [FIFO_DEPTH];

    always_ff @(posedge lclk) begin
        if (push) edb_mem_q[wr_ptr_q] <= in_tlpedb;
    end

    assign lp_tlpedb = lp_irdy ? edb_mem_q[rd_ptr_q] : '0;
`else
    assign lp_tlpedb = '0;
`endif

    assign lp_data         = lp_irdy ? data_mem_q[rd_ptr_q]  : '0;
    assign lp_valid        = lp_irdy ? valid_mem_q[rd_ptr_q] : '0;
    assign lp_tlp_start    = lp_irdy ? ts_mem_q[rd_ptr_q]    : '0;
    assign lp_tlp_end      = lp_irdy ? te_mem_q[rd_ptr_q]    : '0;
    assign lp_dllp_start   = lp_irdy ? ds_mem_q[rd_ptr_q]    : '0;
    assign lp_dllp_end     = lp_irdy ? de_mem_q[rd_ptr_q]    : '0;
    assign lp_state_req    = (state_q == ST_RESET) ? 4'h0 : 4'h1;
    assign lp_force_detect = force_detect_q;
    assign lp_exit_cg_ack  = exit_cg_ack_q;
    assign fifo_level      = level_q;
    assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_lpif_tx_framer.sv
// tb/tb_lpif_tx_framer.sv - directed and randomized bench for lpif_tx_framer against a queue reference model.
module tb_lpif_tx_framer;

    localparam int W   = 256;
    localparam int B   = W / 8;
    localparam int DEP = 8;
    localparam int TO  = 1024;
    localparam int BW  = W + 6 * B;

    typedef struct packed {
        logic [W-1:0] data;
        logic [B-1:0] vb;
        logic [B-1:0] ts;
        logic [B-1:0] te;
        logic [B-1:0] ds;
        logic [B-1:0] de;
        logic [B-1:0] edb;
    } beat_t;

    logic          lclk = 1'b0;
    logic          reset, link_en, force_detect, in_valid, in_ready;
    logic [W-1:0]  in_data;
    logic [B-1:0]  in_valid_b, in_tlp_start, in_tlp_end, in_dllp_start, in_dllp_end, in_tlpedb;
    logic          lp_irdy, pl_trdy;
    logic [W-1:0]  lp_data;
    logic [B-1:0]  lp_valid, lp_tlp_start, lp_tlp_end, lp_dllp_start, lp_dllp_end, lp_tlpedb;
    logic [3:0]    lp_state_req, pl_state_sts;
    logic          lp_force_detect, pl_exit_cg_req, lp_exit_cg_ack;
    logic [3:0]    fifo_level;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;
    beat_t q[$];

    always #5 lclk = ~lclk;

    lpif_tx_framer #(.LPIF_BUS_WIDTH(W), .FIFO_DEPTH(DEP), .ACTIVE_TIMEOUT(TO)) dut (
        .lclk(lclk), .reset(reset), .link_en(link_en), .force_detect(force_detect),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_valid_b(in_valid_b),
        .in_tlp_start(in_tlp_start), .in_tlp_end(in_tlp_end),
        .in_dllp_start(in_dllp_start), .in_dllp_end(in_dllp_end),
`ifdef LPIF_TX_TLPEDB_EN
        .in_tlpedb(in_tlpedb),
`endif
        .lp_irdy(lp_irdy), .pl_trdy(pl_trdy), .lp_data(lp_data), .lp_valid(lp_valid),
        .lp_tlp_start(lp_tlp_start), .lp_tlp_end(lp_tlp_end),
        .lp_dllp_start(lp_dllp_start), .lp_dllp_end(lp_dllp_end), .lp_tlpedb(lp_tlpedb),
        .lp_state_req(lp_state_req), .pl_state_sts(pl_state_sts),
        .lp_force_detect(lp_force_detect), .pl_exit_cg_req(pl_exit_cg_req),
        .lp_exit_cg_ack(lp_exit_cg_ack), .fifo_level(fifo_level), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge lclk);
        #1;
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        for (int i = 0; i < W / 32; i++) b.data[i*32 +: 32] = $urandom;
        b.vb = $urandom;
        b.ts = $urandom;
        b.te = $urandom;
        b.ds = $urandom;
        b.de = $urandom;
`ifdef LPIF_TX_TLPEDB_EN
        b.edb = $urandom;
`else
        b.edb = '0;
`endif
        return b;
    endfunction

    task automatic drive(input beat_t b, input logic v);
        in_valid      = v;
        in_data       = b.data;
        in_valid_b    = b.vb;
        in_tlp_start  = b.ts;
        in_tlp_end    = b.te;
        in_dllp_start = b.ds;
        in_dllp_end   = b.de;
        in_tlpedb     = b.edb;
    endtask

    function automatic beat_t head();
        beat_t h;
        h.data = lp_data;
        h.vb   = lp_valid;
        h.ts   = lp_tlp_start;
        h.te   = lp_tlp_end;
        h.ds   = lp_dllp_start;
        h.de   = lp_dllp_end;
        h.edb  = lp_tlpedb;
        return h;
    endfunction

    task automatic drain(input string tag);
        int guard = 0;
        pl_trdy  = 1'b1;
        in_valid = 1'b0;
        #1;
        while (q.size() != 0 && guard < 4 * DEP) begin
            chk({tag, "_irdy"}, BW'(lp_irdy), BW'(1));
            chk({tag, "_head"}, head(), q[0]);
            tick();
            void'(q.pop_front());
            guard++;
        end
        chk({tag, "_empty_level"}, BW'(fifo_level), BW'(0));
        chk({tag, "_in_ready"}, BW'(in_ready), BW'(1));
    endtask

    initial begin
        beat_t b, h0, prev_head;
        logic  pushx, popx, prev_stall;
        int    n;

        reset = 1'b1; link_en = 1'b0; force_detect = 1'b0; pl_trdy = 1'b0;
        pl_state_sts = 4'h0; pl_exit_cg_req = 1'b0;
        drive('0, 1'b0);
        repeat (3) tick();
        chk("rst_irdy", BW'(lp_irdy), BW'(0));
        chk("rst_head", head(), '0);
        chk("rst_state_req", BW'(lp_state_req), BW'(0));
        chk("rst_level", BW'(fifo_level), BW'(0));
        chk("rst_in_ready", BW'(in_ready), BW'(1));
        chk("rst_misc", BW'({lp_force_detect, lp_exit_cg_ack, timeout_err}), BW'(0));
        reset = 1'b0;

        // Bring-up: link_en, then PHY reports ACTIVE three cycles later.
        link_en = 1'b1;
        repeat (3) tick();
        chk("req_state_req", BW'(lp_state_req), BW'(1));
        pl_state_sts = 4'h1;
        tick();
        chk("up_state_req", BW'(lp_state_req), BW'(1));
        chk("up_irdy_empty", BW'(lp_irdy), BW'(0));

        // Fill to full with the PHY holding off.
        for (int i = 0; i < DEP; i++) begin
            b = rand_beat();
            drive(b, 1'b1);
            #1;
            chk("fill_in_ready", BW'(in_ready), BW'(1));
            tick();
            q.push_back(b);
        end
        chk("full_level", BW'(fifo_level), BW'(DEP));
        chk("full_in_ready", BW'(in_ready), BW'(0));
        chk("full_head_stable", head(), q[0]);
        drive(rand_beat(), 1'b1);
        tick();
        chk("full_refuse_level", BW'(fifo_level), BW'(DEP));
        // Full plus a same-cycle pop must still refuse the write.
        pl_trdy = 1'b1;
        tick();
        void'(q.pop_front());
        chk("full_pop_refuse_level", BW'(fifo_level), BW'(DEP - 1));
        drain("burst");

        // Mid-stream loss of ACTIVE with an unaccepted head.
        pl_trdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            b = rand_beat();
            drive(b, 1'b1);
            tick();
            q.push_back(b);
        end
        in_valid = 1'b0;
        #1;
        chk("stall_irdy_before", BW'(lp_irdy), BW'(1));
        h0 = head();
        chk("stall_head_before", h0, q[0]);
        pl_state_sts = 4'h0;
        #1;
        chk("stall_irdy_drop", BW'(lp_irdy), BW'(0));
        chk("stall_head_zero", head(), '0);
        repeat (3) tick();
        pl_state_sts = 4'h1;
        #1;
        chk("stall_irdy_still", BW'(lp_irdy), BW'(0));
        tick();
        chk("stall_reoffer_irdy", BW'(lp_irdy), BW'(1));
        chk("stall_reoffer_head", head(), h0);

        // Link drop keeps FIFO contents; exit_cg is not acked from RESET.
        link_en = 1'b0;
        tick();
        chk("linkoff_state_req", BW'(lp_state_req), BW'(0));
        chk("linkoff_level", BW'(fifo_level), BW'(2));
        pl_exit_cg_req = 1'b1;
        tick();
        chk("cg_ack_in_reset", BW'(lp_exit_cg_ack), BW'(0));
        pl_exit_cg_req = 1'b0;
        link_en = 1'b1;
        repeat (2) tick();
        chk("relink_irdy", BW'(lp_irdy), BW'(1));
        chk("relink_head", head(), h0);
        pl_exit_cg_req = 1'b1;
        tick();
        chk("cg_ack_rise", BW'(lp_exit_cg_ack), BW'(1));
        pl_exit_cg_req = 1'b0;
        tick();
        chk("cg_ack_fall", BW'(lp_exit_cg_ack), BW'(0));
        force_detect = 1'b1;
        tick();
        chk("fd_out", BW'(lp_force_detect), BW'(1));
        chk("fd_state_req", BW'(lp_state_req), BW'(0));
        force_detect = 1'b0;
        repeat (2) tick();
        chk("fd_out_clear", BW'(lp_force_detect), BW'(0));
        drain("after_fd");

        // Randomized stream with pl_trdy toggling every cycle.
        pl_trdy = 1'b0;
        prev_stall = 1'b0;
        prev_head = '0;
        for (int i = 0; i < 300; i++) begin
            b = rand_beat();
            drive(b, ($urandom_range(0, 3) != 0));
            pl_trdy = ~pl_trdy;
            #1;
            chk("str_irdy", BW'(lp_irdy), BW'(q.size() != 0));
            chk("str_level", BW'(fifo_level), BW'(q.size()));
            chk("str_in_ready", BW'(in_ready), BW'(q.size() != DEP));
            if (q.size() != 0) chk("str_head", head(), q[0]);
            if (prev_stall) chk("str_head_stable", head(), prev_head);
            popx  = (q.size() != 0) && pl_trdy;
            pushx = in_valid && (q.size() != DEP);
            prev_stall = (q.size() != 0) && !pl_trdy;
            prev_head = head();
            tick();
            if (popx) void'(q.pop_front());
            if (pushx) q.push_back(b);
        end
        drain("str_end");

        // Bring-up timeout with the PHY never reaching ACTIVE.
        link_en = 1'b0;
        pl_state_sts = 4'h0;
        tick();
        link_en = 1'b1;
        n = 0;
        while (!timeout_err && n < 2 * TO) begin
            tick();
            n++;
        end
        chk("to_cycles", BW'(n), BW'(TO + 1));
        chk("to_err", BW'(timeout_err), BW'(1));
        chk("to_state_req", BW'(lp_state_req), BW'(0));
        tick();
        chk("to_sticky", BW'(timeout_err), BW'(1));
        chk("to_retry_req", BW'(lp_state_req), BW'(1));
        reset = 1'b1;
        tick();
        chk("to_clear_on_reset", BW'(timeout_err), BW'(0));
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
